instr_mem_loader: RTL and testbench

- Writer-side counterpart to the CPU's read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles bytes big-endian into INSTR_LEN-bit instruction words.
- Issues one single-cycle write per word to sequential instruction-memory addresses, starting at 0.
- Holds the CPU off (cpu_hold) for the whole load, so fetch phases never see a partially loaded program.

---
 rtl/instr_mem_loader.sv | 134 +++++++++++++
 tb/tb_instr_mem_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the CPU instruction memory: packs bytes big-endian into
// instruction words, writes them to sequential addresses, and stalls the CPU meanwhile.
module instr_mem_loader #(
    parameter int unsigned INSTR_LEN     = 32,
    parameter int unsigned MEM_ADDR_SIZE = 5,
    parameter int unsigned NUM_WORDS     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [MEM_ADDR_SIZE-1:0] wr_addr,
    output logic [INSTR_LEN-1:0]     wr_data,
    output logic                     busy,
    output logic                     cpu_hold,
    output logic                     done,
    output logic [MEM_ADDR_SIZE:0]   word_count
);

    localparam int unsigned BYTES = INSTR_LEN / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned WCW   = MEM_ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [INSTR_LEN-1:0]     asm_q, asm_d;
    logic [BCW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [MEM_ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [INSTR_LEN-1:0]     wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d;
    logic [WCW-1:0]           word_count_q, word_count_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [INSTR_LEN-1:0]     asm_shift;

    // Shift the new byte in at the bottom; the oldest byte falls off the top.
    assign asm_shift = INSTR_LEN'({asm_q, byte_in});

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        byte_cnt_d   = byte_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        word_count_d = word_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    asm_d        = '0;
                    byte_cnt_d   = '0;
                    wr_addr_d    = '0;
                    word_count_d = '0;
                end
            end
            S_COLLECT: begin
                if (byte_valid && byte_ready_q) begin
                    asm_d = asm_shift;
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        wr_data_d  = asm_shift;
                        wr_en_d    = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + WCW'(1);
                if (wr_addr_q == MEM_ADDR_SIZE'(NUM_WORDS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    wr_addr_d = wr_addr_q + MEM_ADDR_SIZE'(1);
                    state_d   = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the next state.
        byte_ready_d = (state_d == S_COLLECT);
        busy_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            asm_q        <= '0;
            byte_cnt_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            word_count_q <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            word_count_q <= word_count_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes go into a scoreboard queue
// when words are fed, and are popped and checked whenever wr_en is observed.
module tb_instr_mem_loader;

    localparam int unsigned IL = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IL-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IL-1:0] wr_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic [AW:0]   word_count;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   last_wr    = -1;
    bit   gap_check  = 1'b0;
    logic prev_wr    = 1'b0;
    exp_t sb[$];

    instr_mem_loader #(
        .INSTR_LEN    (IL),
        .MEM_ADDR_SIZE(AW),
        .NUM_WORDS    (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: every observed write must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            chk("wr_en_single_cycle", 64'(prev_wr), 64'd0);
            chk("write_byte_ready", 64'(byte_ready), 64'd0);
            chk("write_cpu_hold", 64'(cpu_hold), 64'd1);
            chk("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
                chk("word_count_at_write", 64'(word_count), 64'(e.addr));
            end
            if (gap_check && last_wr >= 0)
                chk("word_period", 64'(cyc - last_wr), 64'd5);
            last_wr = cyc;
        end
        prev_wr = wr_en;
    end

    // Present a byte at a negedge and return at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_accept_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [IL-1:0] d);
        sb.push_back('{addr: a, data: d});
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_byte_ready", 64'(byte_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Basic load of four small words, byte_valid held high throughout.
        gap_check = 1'b1;
        last_wr   = -1;
        pulse_start();
        chk("collect_busy", 64'(busy), 64'd1);
        chk("collect_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("collect_byte_ready", 64'(byte_ready), 64'd1);
        for (int w = 0; w < 4; w++) send_word(AW'(w), IL'(w));
        byte_valid = 1'b0;
        wait_done();
        gap_check = 1'b0;
        chk("basic_word_count", 64'(word_count), 64'd4);
        chk("basic_busy", 64'(busy), 64'd0);
        chk("basic_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("basic_byte_ready", 64'(byte_ready), 64'd0);
        chk("basic_addr_held", 64'(wr_addr), 64'd3);

        // Restart from DONE: byte order, stall gap, start while busy.
        pulse_start();
        chk("restart_done_drop", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_word_count", 64'(word_count), 64'd0);
        chk("restart_addr", 64'(wr_addr), 64'd0);
        send_word(AW'(0), 32'hDEADBEEF);
        sb.push_back('{addr: AW'(1), data: 32'h12345678});
        send_byte(8'h12);
        send_byte(8'h34);
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_byte_ready", 64'(byte_ready), 64'd1);
            chk("stall_no_write", 64'(wr_en), 64'd0);
            @(negedge clk);
        end
        send_byte(8'h56);
        send_byte(8'h78);
        sb.push_back('{addr: AW'(2), data: 32'hCAFEF00D});
        send_byte(8'hCA);
        send_byte(8'hFE);
        start = 1'b1;
        send_byte(8'hF0);
        start = 1'b0;
        send_byte(8'h0D);
        chk("in_write_state", 64'(wr_en), 64'd1);
        pulse_start();
        chk("busy_start_addr", 64'(wr_addr), 64'd3);
        chk("busy_start_count", 64'(word_count), 64'd3);
        send_word(AW'(3), 32'h0BADC0DE);
        byte_valid = 1'b0;
        wait_done();
        chk("restart_final_count", 64'(word_count), 64'd4);

        // Reset mid-load with a partial word pending.
        pulse_start();
        send_word(AW'(0), 32'h01020304);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 64'(busy), 64'd0);
        pulse_start();
        send_word(AW'(0), 32'h11223344);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reload_word_count", 64'(word_count), 64'd1);
        chk("reload_next_addr", 64'(wr_addr), 64'd1);
        chk("reload_busy", 64'(busy), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
